// File: rtl/adc128s022_emu_if.sv
// ADC128S022 serial pins as seen between a controller (master) and the converter (slave).
interface adc128s022_emu_if;
   logic adc_cs_n;
   logic adc_sclk;
   logic adc_din;
   logic adc_dout;
   logic adc_dout_oe;

   modport master (
      output adc_cs_n,
      output adc_sclk,
      output adc_din,
      input  adc_dout,
      input  adc_dout_oe
   );

   modport slave (
      input  adc_cs_n,
      input  adc_sclk,
      input  adc_din,
      output adc_dout,
      output adc_dout_oe
   );
endinterface

// File: rtl/adc128s022_emu.sv
// ADC128S022 responder: oversamples the SPI pins in the clk domain and shifts out
// {4'b0, sample} per 16-SCLK frame, using the channel address sent in the previous frame.
module adc128s022_emu (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [95:0]            ch_data,
   adc128s022_emu_if.slave        spi,
   output logic                   frame_done,
   output logic [2:0]             frame_ch,
   output logic                   frame_abort
);

   typedef enum logic [0:0] {StIdle = 1'b0, StShift = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [2:0]  cs_sync_q;
   logic [2:0]  sclk_sync_q;
   logic [1:0]  din_sync_q;
   logic [3:0]  bit_cnt_q;
   logic [15:0] shreg_q;
   logic [2:0]  addr_reg_q;
   logic [2:0]  addr_cap_q;
   logic [11:0] sample [8];

   logic cs_fall, cs_rise, sclk_fall, sclk_rise, din_s;

   // Bit [1] is the synchronized level, bit [2] the previous one.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync_q   <= 3'b111;
         sclk_sync_q <= 3'b111;
         din_sync_q  <= 2'b00;
      end else begin
         cs_sync_q   <= {cs_sync_q[1:0], spi.adc_cs_n};
         sclk_sync_q <= {sclk_sync_q[1:0], spi.adc_sclk};
         din_sync_q  <= {din_sync_q[0], spi.adc_din};
      end
   end

   assign cs_fall   = !cs_sync_q[1] && cs_sync_q[2];
   assign cs_rise   = cs_sync_q[1] && !cs_sync_q[2];
   assign sclk_fall = !sclk_sync_q[1] && sclk_sync_q[2];
   assign sclk_rise = sclk_sync_q[1] && !sclk_sync_q[2];
   assign din_s     = din_sync_q[1];

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         sample[i] = ch_data[12*i +: 12];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cs_fall) state_d = StShift;
         StShift: if (cs_rise) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      spi.adc_dout_oe = 1'b0;
      spi.adc_dout    = 1'b0;
      if (state_q == StShift) begin
         spi.adc_dout_oe = 1'b1;
         spi.adc_dout    = shreg_q[15];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q   <= 4'd0;
         shreg_q     <= 16'd0;
         addr_reg_q  <= 3'd0;
         addr_cap_q  <= 3'd0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         frame_ch    <= 3'd0;
      end else begin
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         if (state_q == StIdle) begin
            if (cs_fall) begin
               bit_cnt_q <= 4'd0;
               shreg_q   <= {4'b0000, sample[addr_reg_q]};
            end
         end else if (cs_rise) begin
            // CS wins over a coincident SCLK edge; a frame with no rises ends silently.
            if (bit_cnt_q != 4'd0) frame_abort <= 1'b1;
         end else if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            case (bit_cnt_q)
               4'd2:    addr_cap_q[2] <= din_s;
               4'd3:    addr_cap_q[1] <= din_s;
               4'd4:    addr_cap_q[0] <= din_s;
               default: ;
            endcase
            if (bit_cnt_q == 4'd15) begin
               frame_done <= 1'b1;
               frame_ch   <= addr_reg_q;
               addr_reg_q <= addr_cap_q;
               shreg_q    <= {4'b0000, sample[addr_cap_q]};
            end
         end else if (sclk_fall && bit_cnt_q != 4'd0) begin
            // The fall ahead of a frame's first rise keeps bit 15 on the line, so
            // rises 1..16 read shreg bits 15..0.
            shreg_q <= {shreg_q[14:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_adc128s022_emu.sv
// Directed bench for adc128s022_emu: a pin-level SPI controller plus a frame vector table.
module tb_adc128s022_emu;

   logic        clk = 1'b0;
   logic        rst;
   logic [95:0] ch_data;
   logic        frame_done;
   logic        frame_abort;
   logic [2:0]  frame_ch;

   adc128s022_emu_if spi ();

   adc128s022_emu dut (
      .clk         (clk),
      .rst         (rst),
      .ch_data     (ch_data),
      .spi         (spi),
      .frame_done  (frame_done),
      .frame_ch    (frame_ch),
      .frame_abort (frame_abort)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int done_pulses = 0;
   int abort_pulses = 0;

   // Each high cycle counts, so a stretched pulse shows up as an extra count.
   always @(negedge clk) begin
      if (frame_done === 1'b1) done_pulses++;
      if (frame_abort === 1'b1) abort_pulses++;
   end

   typedef struct {
      logic [2:0]  addr;
      int          rises;
      logic [15:0] exp_bits;
      int          exp_done;
      int          exp_abort;
      logic [2:0]  exp_ch;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [11:0] v);
      ch_data[12*ch +: 12] = v;
   endtask

   // Rises numbered first..first+n-1 within the frame; rises 3..5 carry the address.
   task automatic spi_rises(input logic [2:0] addr, input int first, input int n,
                            inout logic [15:0] bits);
      for (int i = first; i < first + n; i++) begin
         spi.adc_din  = (i == 3) ? addr[2] : (i == 4) ? addr[1] : (i == 5) ? addr[0] : 1'b0;
         spi.adc_sclk = 1'b0;
         tick(4);
         bits = {bits[14:0], spi.adc_dout};
         spi.adc_sclk = 1'b1;
         tick(4);
      end
   endtask

   task automatic run_frame(input logic [2:0] addr, input int n, output logic [15:0] bits);
      bits = 16'd0;
      spi.adc_cs_n = 1'b0;
      tick(4);
      check("oe_in_frame", 32'(spi.adc_dout_oe), 32'd1);
      spi_rises(addr, 1, n, bits);
      spi.adc_cs_n = 1'b1;
      tick(6);
      check("oe_idle", 32'(spi.adc_dout_oe), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] bits;
      int d0, a0;

      rst          = 1'b1;
      spi.adc_cs_n = 1'b1;
      spi.adc_sclk = 1'b1;
      spi.adc_din  = 1'b0;
      ch_data      = 96'd0;
      set_ch(0, 12'hA5C);
      set_ch(1, 12'h3B1);
      set_ch(2, 12'hC4E);
      set_ch(3, 12'h123);
      set_ch(4, 12'h777);
      set_ch(5, 12'h9D2);
      set_ch(6, 12'hE0F);
      set_ch(7, 12'h5A6);

      vecs[0] = '{3'd3, 16, 16'h0A5C, 1, 0, 3'd0};
      vecs[1] = '{3'd5, 16, 16'h0123, 1, 0, 3'd3};
      vecs[2] = '{3'd0, 16, 16'h09D2, 1, 0, 3'd5};
      vecs[3] = '{3'd6, 7,  16'h0005, 0, 1, 3'd5};  // abort: first 7 bits of ch0
      vecs[4] = '{3'd7, 16, 16'h0A5C, 1, 0, 3'd0};
      vecs[5] = '{3'd2, 16, 16'h05A6, 1, 0, 3'd7};
      vecs[6] = '{3'd4, 0,  16'h0000, 0, 0, 3'd7};  // CS pulse with no SCLK
      vecs[7] = '{3'd1, 16, 16'h0C4E, 1, 0, 3'd2};

      tick(3);
      rst = 1'b0;
      tick(2);
      check("rst_dout", 32'(spi.adc_dout), 32'd0);
      check("rst_oe", 32'(spi.adc_dout_oe), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_abort", 32'(frame_abort), 32'd0);
      check("rst_frame_ch", 32'(frame_ch), 32'd0);

      for (int k = 0; k < 8; k++) begin
         d0 = done_pulses;
         a0 = abort_pulses;
         run_frame(vecs[k].addr, vecs[k].rises, bits);
         check($sformatf("vec%0d_bits", k), 32'(bits), 32'(vecs[k].exp_bits));
         check($sformatf("vec%0d_done", k), 32'(done_pulses - d0), 32'(vecs[k].exp_done));
         check($sformatf("vec%0d_abort", k), 32'(abort_pulses - a0), 32'(vecs[k].exp_abort));
         check($sformatf("vec%0d_frame_ch", k), 32'(frame_ch), 32'(vecs[k].exp_ch));
      end

      // Continuous frames with CS held low; addr_reg is 1 here.
      d0 = done_pulses;
      a0 = abort_pulses;
      spi.adc_cs_n = 1'b0;
      tick(4);
      bits = 16'd0;
      spi_rises(3'd1, 1, 16, bits);
      check("cont1_bits", 32'(bits), 32'h03B1);
      check("cont1_done", 32'(done_pulses - d0), 32'd1);
      check("cont1_frame_ch", 32'(frame_ch), 32'd1);
      bits = 16'd0;
      spi_rises(3'd2, 1, 16, bits);
      check("cont2_bits", 32'(bits), 32'h03B1);
      check("cont2_done", 32'(done_pulses - d0), 32'd2);
      check("cont2_frame_ch", 32'(frame_ch), 32'd1);
      bits = 16'd0;
      spi_rises(3'd0, 1, 16, bits);
      check("cont3_bits", 32'(bits), 32'h0C4E);
      check("cont3_frame_ch", 32'(frame_ch), 32'd2);
      spi.adc_cs_n = 1'b1;
      tick(6);
      check("cont_done_total", 32'(done_pulses - d0), 32'd3);
      check("cont_abort", 32'(abort_pulses - a0), 32'd0);

      // ch_data change mid-frame must not disturb the latched sample (addr_reg is 0).
      set_ch(0, 12'hFFF);
      spi.adc_cs_n = 1'b0;
      tick(4);
      bits = 16'd0;
      spi_rises(3'd3, 1, 5, bits);
      set_ch(0, 12'h000);
      spi_rises(3'd3, 6, 11, bits);
      spi.adc_cs_n = 1'b1;
      tick(6);
      check("latch_bits", 32'(bits), 32'h0FFF);
      set_ch(0, 12'hA5C);

      // Reset at rise 9 with addr_reg = 3; the next frame must return ch0.
      d0 = done_pulses;
      a0 = abort_pulses;
      spi.adc_cs_n = 1'b0;
      tick(4);
      bits = 16'd0;
      spi_rises(3'd6, 1, 9, bits);
      rst          = 1'b1;
      spi.adc_cs_n = 1'b1;
      tick(1);
      check("midrst_oe", 32'(spi.adc_dout_oe), 32'd0);
      check("midrst_dout", 32'(spi.adc_dout), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(6);
      check("midrst_done", 32'(done_pulses - d0), 32'd0);
      check("midrst_abort", 32'(abort_pulses - a0), 32'd0);
      run_frame(3'd0, 16, bits);
      check("postrst_bits", 32'(bits), 32'h0A5C);
      check("postrst_frame_ch", 32'(frame_ch), 32'd0);
      check("postrst_done", 32'(done_pulses - d0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
